// File: rtl/j1_io_arbiter.sv
// Shares the j1 peripheral I/O bus between the CPU (absolute priority, combinational pass-through)
// and one secondary master M1 whose single request is captured, issued when the bus is idle, and acked.
module j1_io_arbiter #(
  parameter logic [15:0] STAT_ADDR    = 16'hFFFE,
  parameter logic [7:0]  STARVE_LIMIT = 8'd255
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_wdata_i,
  output logic [15:0] cpu_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_wdata_i,
  output logic        m1_busy_o,
  output logic        m1_ack_o,
  output logic [15:0] m1_rdata_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  input  logic [15:0] bus_rdata_i,
  output logic        starve_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        starve_q, starve_d;

  logic        cpu_acc, cpu_stat, cpu_hit, m1_issue;
  logic [15:0] status;

  always_comb begin
    cpu_acc  = cpu_rd_i | cpu_wr_i;
    cpu_stat = cpu_acc & (cpu_addr_i == STAT_ADDR);
    cpu_hit  = cpu_acc & (cpu_addr_i != STAT_ADDR);
    // Gated by reset so a request caught in WAIT never reaches the bus on the reset cycle.
    m1_issue = (state_q == S_WAIT) & ~cpu_hit & sys_rst_i;
    status   = {starve_q, 5'b0, state_q, wait_cnt_q};

    bus_rd_o    = 1'b0;
    bus_wr_o    = 1'b0;
    bus_addr_o  = 16'h0000;
    bus_wdata_o = 16'h0000;
    if (cpu_hit) begin
      bus_rd_o    = cpu_rd_i;
      bus_wr_o    = cpu_wr_i;
      bus_addr_o  = cpu_addr_i;
      bus_wdata_o = cpu_wdata_i;
    end else if (m1_issue) begin
      bus_rd_o    = ~we_q;
      bus_wr_o    = we_q;
      bus_addr_o  = addr_q;
      bus_wdata_o = wdata_q;
    end
    cpu_rdata_o = cpu_stat ? status : bus_rdata_i;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    starve_d   = starve_q;
    case (state_q)
      S_IDLE: begin
        if (m1_req_i) begin
          we_d       = m1_we_i;
          addr_d     = m1_addr_i;
          wdata_d    = m1_wdata_i;
          wait_cnt_d = 8'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cpu_hit) begin
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (wait_cnt_d == STARVE_LIMIT) starve_d = 1'b1;
          end
        end else begin
          rdata_d = we_q ? 16'h0000 : bus_rdata_i;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cpu_stat && cpu_wr_i && cpu_wdata_i[0]) starve_d = 1'b0;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      rdata_q    <= 16'h0000;
      wait_cnt_q <= 8'd0;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign m1_busy_o  = (state_q != S_IDLE);
  assign m1_ack_o   = (state_q == S_ACK);
  assign m1_rdata_o = rdata_q;
  assign starve_o   = starve_q;

endmodule

// File: tb/tb_j1_io_arbiter.sv
// Directed bench for j1_io_arbiter (STARVE_LIMIT=4): per-cycle vector table plus a saturation sequence.
module tb_j1_io_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr, m1_req, m1_we;
  logic [15:0] cpu_addr, cpu_wdata, m1_addr, m1_wdata, bus_rdata;
  logic [15:0] cpu_rdata, m1_rdata, bus_addr, bus_wdata;
  logic        m1_busy, m1_ack, bus_rd, bus_wr, starve;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  j1_io_arbiter #(.STAT_ADDR(16'hFFFE), .STARVE_LIMIT(8'd4)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_busy_o(m1_busy), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .bus_rd_o(bus_rd), .bus_wr_o(bus_wr), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .starve_o(starve)
  );

  typedef struct packed {
    logic rst, rd, wr; logic [15:0] caddr, cwd;
    logic req, we; logic [15:0] maddr, mwd, brd;
  } in_t;
  typedef struct packed {
    logic busy, ack; logic [15:0] mrd;
    logic brd, bwr; logic [15:0] baddr, bwd, crd; logic starve;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  task automatic drive(input in_t v);
    rst = v.rst; cpu_rd = v.rd; cpu_wr = v.wr; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    m1_req = v.req; m1_we = v.we; m1_addr = v.maddr; m1_wdata = v.mwd; bus_rdata = v.brd;
  endtask

  function automatic out_t sample();
    out_t g;
    g = '{m1_busy, m1_ack, m1_rdata, bus_rd, bus_wr, bus_addr, bus_wdata, cpu_rdata, starve};
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  initial begin
    out_t g;
    in_t  idle_in;
    idle_in = '{1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0};

    // Reset held with a pending request, then an M1 read
    for (int k = 0; k < 3; k++)
      vt[k] = '{'{0,0,0,16'h0,16'h0,1,0,16'h4002,16'h0,16'h0}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h0,0}};
    vt[3]  = '{'{1,0,0,16'h0,16'h0,1,0,16'h4002,16'h0,16'hBEEF}, '{0,0,16'h0,0,0,16'h0,16'h0,16'hBEEF,0}};
    vt[4]  = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'hBEEF}, '{1,0,16'h0,1,0,16'h4002,16'h0,16'hBEEF,0}};
    vt[5]  = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{1,1,16'hBEEF,0,0,16'h0,16'h0,16'h0,0}};
    // M1 write blocked by 10 CPU writes; starve sets after 4 wait cycles
    vt[6]  = '{'{1,0,1,16'h4000,16'h5555,1,1,16'h4004,16'h1234,16'h0}, '{0,0,16'hBEEF,0,1,16'h4000,16'h5555,16'h0,0}};
    for (int k = 7; k < 11; k++)
      vt[k] = '{'{1,0,1,16'h4000,16'h5555,0,0,16'h0,16'h0,16'h0}, '{1,0,16'hBEEF,0,1,16'h4000,16'h5555,16'h0,0}};
    for (int k = 11; k < 16; k++)
      vt[k] = '{'{1,0,1,16'h4000,16'h5555,0,0,16'h0,16'h0,16'h0}, '{1,0,16'hBEEF,0,1,16'h4000,16'h5555,16'h0,1}};
    vt[16] = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{1,0,16'hBEEF,0,1,16'h4004,16'h1234,16'h0,1}};
    vt[17] = '{'{1,0,0,16'h0,16'h0,1,0,16'h4008,16'h0,16'h0}, '{1,1,16'h0,0,0,16'h0,16'h0,16'h0,1}};
    // Status read/clear: {starve, 0, state=IDLE, wait_cnt=9}
    vt[18] = '{'{1,1,0,16'hFFFE,16'h0,0,0,16'h0,16'h0,16'h7777}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h8009,1}};
    vt[19] = '{'{1,0,1,16'hFFFE,16'h0001,0,0,16'h0,16'h0,16'h7777}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h8009,1}};
    // M1 read of STAT_ADDR issues alongside a CPU status read
    vt[20] = '{'{1,0,0,16'h0,16'h0,1,0,16'hFFFE,16'h0,16'h0}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h0,0}};
    vt[21] = '{'{1,1,0,16'hFFFE,16'h0,0,0,16'h0,16'h0,16'hABCD}, '{1,0,16'h0,1,0,16'hFFFE,16'h0,16'h0100,0}};
    vt[22] = '{'{1,1,0,16'hFFFE,16'h0,0,0,16'h0,16'h0,16'h0}, '{1,1,16'hABCD,0,0,16'h0,16'h0,16'h0200,0}};
    // Reset while in WAIT, then a fresh request with 2-cycle latency
    vt[23] = '{'{1,0,0,16'h0,16'h0,1,1,16'h4010,16'h00AA,16'h0}, '{0,0,16'hABCD,0,0,16'h0,16'h0,16'h0,0}};
    vt[24] = '{'{0,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{1,0,16'hABCD,0,0,16'h0,16'h0,16'h0,0}};
    vt[25] = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h0,0}};
    vt[26] = '{'{1,0,0,16'h0,16'h0,1,0,16'h4020,16'h0,16'h1111}, '{0,0,16'h0,0,0,16'h0,16'h0,16'h1111,0}};
    vt[27] = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h1111}, '{1,0,16'h0,1,0,16'h4020,16'h0,16'h1111,0}};
    vt[28] = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{1,1,16'h1111,0,0,16'h0,16'h0,16'h0,0}};
    vt[29] = '{'{1,0,0,16'h0,16'h0,0,0,16'h0,16'h0,16'h0}, '{0,0,16'h1111,0,0,16'h0,16'h0,16'h0,0}};

    // Unchecked first reset edge so registered outputs are defined
    drive('{1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0});
    @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vt[k].i);
      #1;
      g = sample();
      total++;
      if (g !== vt[k].o) begin
        bad++;
        $display("FAIL vec%0d: got %h want %h", k, g, vt[k].o);
      end
    end

    // Wait counter saturates at 255 under a long CPU burst
    @(negedge clk);
    drive(idle_in);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h4030;
    @(negedge clk);
    drive(idle_in);
    cpu_rd = 1'b1; cpu_addr = 16'h4000;
    #1;
    chk("sat_cpu_owns_bus", {15'd0, bus_rd, bus_addr}, {15'd0, 1'b1, 16'h4000});
    for (int k = 0; k < 299; k++) @(negedge clk);
    @(negedge clk);
    drive(idle_in);
    cpu_rd = 1'b1; cpu_addr = 16'hFFFE; bus_rdata = 16'h5A5A;
    #1;
    chk("sat_status", {16'd0, cpu_rdata}, 32'h0000_81FF);
    chk("sat_m1_issue", {15'd0, bus_rd, bus_addr}, {15'd0, 1'b1, 16'h4030});
    @(negedge clk);
    drive(idle_in);
    #1;
    chk("sat_ack", {14'd0, m1_ack, starve, m1_rdata}, {14'd0, 1'b1, 1'b1, 16'h5A5A});
    @(negedge clk);
    drive(idle_in);
    cpu_wr = 1'b1; cpu_addr = 16'hFFFE; cpu_wdata = 16'h0001;
    #1;
    chk("clr_no_strobe", {30'd0, bus_rd, bus_wr}, 32'd0);
    @(negedge clk);
    drive(idle_in);
    #1;
    chk("starve_cleared", {31'd0, starve}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
